// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse line: FSM states and the default frame
// timing that both the generator and this checker are built against.
package pulse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIGH,
      ST_GAP,
      ST_LONG
   } state_t;

   localparam int unsigned DEF_PULSE_LEN = 3;
   localparam int unsigned DEF_GAP_LEN   = 2;

   // Width that holds the larger of the two run lengths.
   function automatic int unsigned run_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pulse_frame_checker_run_counter.sv
// Saturating run-length counter with synchronous clear and load-to-one.
module run_counter #(
   parameter int unsigned W   = 2,
   parameter int unsigned MAX = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load1,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] MAX_C = W'(MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load1) begin
         cnt <= W'(1);
      end else if (inc && (cnt != MAX_C)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pulse_frame_checker.sv
// Receive-side checker for the fixed-width pulse line: validates high width and
// low guard per frame, strobes valid/error and counts good frames.
module pulse_frame_checker
   import pulse_pkg::*;
#(
   parameter int unsigned PULSE_LEN = DEF_PULSE_LEN,
   parameter int unsigned GAP_LEN   = DEF_GAP_LEN,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             y_in,
   input  logic             clr_cnt,
   output logic             valid,
   output logic             err_short,
   output logic             err_long,
   output logic             err_gap,
   output logic [CNT_W-1:0] pulse_count
);

   localparam int unsigned      RUN_W  = run_width(PULSE_LEN, GAP_LEN);
   localparam logic [RUN_W-1:0] H_FULL = RUN_W'(PULSE_LEN);
   localparam logic [RUN_W-1:0] G_LAST = RUN_W'(GAP_LEN - 1);

   state_t           state, state_nx;
   logic [RUN_W-1:0] hcnt, gcnt;
   logic             h_load, h_inc, g_load, g_inc, run_clr;
   logic             valid_nx, es_nx, el_nx, eg_nx;

   run_counter #(.W(RUN_W), .MAX(PULSE_LEN)) u_hcnt (
      .clk   (clk),
      .rst   (rst),
      .load1 (h_load),
      .inc   (h_inc),
      .clr   (run_clr),
      .cnt   (hcnt)
   );

   run_counter #(.W(RUN_W), .MAX(GAP_LEN)) u_gcnt (
      .clk   (clk),
      .rst   (rst),
      .load1 (g_load),
      .inc   (g_inc),
      .clr   (run_clr),
      .cnt   (gcnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      h_load   = 1'b0;
      h_inc    = 1'b0;
      g_load   = 1'b0;
      g_inc    = 1'b0;
      valid_nx = 1'b0;
      es_nx    = 1'b0;
      el_nx    = 1'b0;
      eg_nx    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (y_in) begin
               state_nx = ST_HIGH;
               h_load   = 1'b1;
            end
         end
         ST_HIGH: begin
            if (y_in) begin
               if (hcnt < H_FULL) begin
                  h_inc = 1'b1;
               end else begin
                  el_nx    = 1'b1;
                  state_nx = ST_LONG;
               end
            end else if (hcnt == H_FULL) begin
               if (GAP_LEN == 1) begin
                  valid_nx = 1'b1;
                  state_nx = ST_IDLE;
               end else begin
                  g_load   = 1'b1;
                  state_nx = ST_GAP;
               end
            end else begin
               es_nx    = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         ST_GAP: begin
            // A rise inside the guard is both an error and the start of the next frame.
            if (y_in) begin
               eg_nx    = 1'b1;
               h_load   = 1'b1;
               state_nx = ST_HIGH;
            end else if (gcnt == G_LAST) begin
               valid_nx = 1'b1;
               state_nx = ST_IDLE;
            end else begin
               g_inc = 1'b1;
            end
         end
         ST_LONG: begin
            if (!y_in) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      run_clr = (state_nx == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid       <= 1'b0;
         err_short   <= 1'b0;
         err_long    <= 1'b0;
         err_gap     <= 1'b0;
         pulse_count <= '0;
      end else begin
         valid     <= valid_nx;
         err_short <= es_nx;
         err_long  <= el_nx;
         err_gap   <= eg_nx;
         if (clr_cnt)       pulse_count <= '0;
         else if (valid_nx) pulse_count <= pulse_count + CNT_W'(1);
      end
   end

endmodule
